// File: rtl/alu_control_md.sv
// EX-stage ALU control: combinational ALUop/funct decode plus a multicycle
// signed/unsigned multiply/divide engine owning the HI/LO registers.
module alu_control_md #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        func,
  input  logic              issue,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [3:0]        ALUControl,
  output logic              jr,
  output logic              illegal,
  output logic              stall,
  output logic              md_busy,
  output logic [DATA_W-1:0] mf_data
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  // Magnitude of a possibly-signed operand; the most negative value maps to 2^(DATA_W-1).
  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
    if (sgn && x[DATA_W-1]) begin
      mag = -x;
    end else begin
      mag = x;
    end
  endfunction

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   p_q, p_d;
  logic [DATA_W-1:0]     opnd_q, opnd_d;
  logic [DATA_W-1:0]     a_orig_q, a_orig_d;
  logic [DATA_W-1:0]     hi_q, hi_d;
  logic [DATA_W-1:0]     lo_q, lo_d;
  logic                  neg_lo_q, neg_lo_d;
  logic                  neg_hi_q, neg_hi_d;
  logic                  div0_q, div0_d;
  logic                  is_mul_q, is_mul_d;
  logic                  md_busy_q, md_busy_d;

  logic                  is_md_fn_s;
  logic                  md_op_s;
  logic                  accept_s;
  logic                  sgn_s;
  logic [DATA_W:0]       mul_sum_s;
  logic [DATA_W:0]       div_sh_s;
  logic [DATA_W:0]       div_diff_s;
  logic                  div_ge_s;
  logic [2*DATA_W-1:0]   prod_fix_s;

  // Funct decode into ALU control code, jr and illegal flags.
  always_comb begin
    ALUControl = 4'b1111;
    jr         = 1'b0;
    illegal    = 1'b0;
    is_md_fn_s = 1'b0;
    case (func)
      F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO: is_md_fn_s = 1'b1;
      default: is_md_fn_s = 1'b0;
    endcase
    case (ALUop)
      2'b00: ALUControl = 4'b0010;
      2'b01: ALUControl = 4'b0110;
      2'b11: ALUControl = 4'b0001;
      default: begin
        case (func)
          F_ADD: ALUControl = 4'b0010;
          F_SUB: ALUControl = 4'b0110;
          F_AND: ALUControl = 4'b0000;
          F_OR:  ALUControl = 4'b0001;
          F_XOR: ALUControl = 4'b0011;
          F_NOR: ALUControl = 4'b1100;
          F_SLT: ALUControl = 4'b0111;
          F_SLL: ALUControl = 4'b1000;
          F_SRL: ALUControl = 4'b1001;
          F_JR:  jr = 1'b1;
          default: illegal = ~is_md_fn_s;
        endcase
      end
    endcase
  end

  assign md_op_s  = issue & (ALUop == 2'b10) & is_md_fn_s;
  assign stall    = md_op_s & md_busy_q;
  assign accept_s = md_op_s & ~md_busy_q;
  assign md_busy  = md_busy_q;
  assign mf_data  = (func == F_MFHI) ? hi_q : lo_q;
  assign sgn_s    = (func == F_MULT) || (func == F_DIV);

  // Shift-add keeps the multiplier in the low half and the running sum in the high half.
  assign mul_sum_s  = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh_s   = {p_q[2*DATA_W-1:DATA_W], p_q[DATA_W-1]};
  assign div_diff_s = div_sh_s - {1'b0, opnd_q};
  assign div_ge_s   = ~div_diff_s[DATA_W];
  assign prod_fix_s = neg_lo_q ? -p_q : p_q;

  // Engine next-state: operand capture, iterations, sign fix and HI/LO writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    opnd_d    = opnd_q;
    a_orig_d  = a_orig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;
    is_mul_d  = is_mul_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (func)
            F_MTHI: hi_d = a;
            F_MTLO: lo_d = a;
            F_MULT, F_MULTU: begin
              state_d  = S_MUL;
              cnt_d    = '0;
              is_mul_d = 1'b1;
              opnd_d   = mag(a, sgn_s);
              p_d      = {{DATA_W{1'b0}}, mag(b, sgn_s)};
              neg_lo_d = sgn_s & (a[DATA_W-1] ^ b[DATA_W-1]);
              neg_hi_d = 1'b0;
              div0_d   = 1'b0;
            end
            F_DIV, F_DIVU: begin
              state_d  = S_DIV;
              cnt_d    = '0;
              is_mul_d = 1'b0;
              opnd_d   = mag(b, sgn_s);
              p_d      = {{DATA_W{1'b0}}, mag(a, sgn_s)};
              neg_lo_d = sgn_s & (a[DATA_W-1] ^ b[DATA_W-1]);
              neg_hi_d = sgn_s & a[DATA_W-1];
              div0_d   = (b == '0);
              a_orig_d = a;
            end
            default: state_d = S_IDLE;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          p_d = {mul_sum_s, p_q[DATA_W-1:1]};
        end else begin
          p_d = {(div_ge_s ? div_diff_s[DATA_W-1:0] : div_sh_s[DATA_W-1:0]),
                 p_q[DATA_W-2:0], div_ge_s};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (is_mul_q) begin
          {hi_d, lo_d} = prod_fix_s;
        end else if (div0_q) begin
          lo_d = '1;
          hi_d = a_orig_q;
        end else begin
          lo_d = neg_lo_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
          hi_d = neg_hi_q ? -p_q[2*DATA_W-1:DATA_W] : p_q[2*DATA_W-1:DATA_W];
        end
      end
      default: state_d = S_IDLE;
    endcase
    md_busy_d = (state_d != S_IDLE);
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      opnd_q    <= '0;
      a_orig_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
      is_mul_q  <= 1'b0;
      md_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      opnd_q    <= opnd_d;
      a_orig_q  <= a_orig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
      is_mul_q  <= is_mul_d;
      md_busy_q <= md_busy_d;
    end
  end

endmodule

// File: doc/alu_control_md.md
# alu_control_md

Parametrised next-generation ALU control unit for the MIPS-subset processor, placed in the EX stage beside the ALU. It keeps the combinational ALUop/funct decode, widened to a 4-bit ALU control code with more R-type operations. It adds a multicycle signed/unsigned multiply/divide engine with HI/LO registers, mfhi/mflo/mthi/mtlo support and a stall handshake back to the pipeline.

## Interface
- DATA_W, 32, operand width; even, ≥ 4; HI and LO are DATA_W bits each
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ALUop  in  2  from main control
- func  in  6  instruction funct field
- issue  in  1  EX-stage instruction valid
- a  in  DATA_W  rs operand
- b  in  DATA_W  rt operand
- ALUControl  out  4  ALU operation code (combinational)
- jr  out  1  jump-register decode (combinational)
- illegal  out  1  ALUop=10 with an undefined funct (combinational)
- stall  out  1  pipeline must hold the EX instruction this cycle
- md_busy  out  1  multiply/divide engine not idle (registered)
- mf_data  out  DATA_W  HI when func=010000, otherwise LO (combinational)

## Operation
- Decode:
  - ALUop 00 → 0010 (ADD).
  - ALUop 01 → 0110 (SUB).
  - ALUop 11 → 0001 (OR, for ori).
  - ALUop 10, by funct: 100000 ADD 0010; 100010 SUB 0110; 100100 AND 0000; 100101 OR 0001; 100110 XOR 0011; 100111 NOR 1100; 101010 SLT 0111; 000000 SLL 1000; 000010 SRL 1001.
  - jr (001000) and all MD functs → 1111 (ALU idle).
  - Any other funct → 1111 with illegal=1.
- jr=1 only for ALUop=10, func=001000. illegal=0 whenever ALUop≠10.
- MD functs: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
- md_op = issue & ALUop==10 & funct is an MD funct. stall = md_op & md_busy.
- An md_op with stall=0 is accepted at the clock edge:
  - mthi writes HI←a, or mtlo writes LO←a, at that edge.
  - mfhi/mflo: the pipeline captures mf_data that cycle; no state change.
  - mult/multu/div/divu: operands latched, and the FSM leaves IDLE.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on mult/multu; IDLE → DIV on div/divu.
  - MUL or DIV → FIX after DATA_W iterations.
  - FIX → IDLE unconditionally.
- Signed ops run on magnitudes:
  - |x| is computed as a DATA_W-bit unsigned value, so the most negative value is handled correctly.
  - Product sign = sign(a)^sign(b).
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
  - Negation is applied in FIX.
- MUL: shift-add, one multiplier bit per cycle, 2·DATA_W-bit accumulator. FIX writes HI:LO = product.
- DIV: restoring division, one quotient bit per cycle. FIX writes LO = quotient, HI = remainder.
- Divide by zero (b=0, signed or unsigned): FIX writes LO = all ones, HI = a as issued (original value, no sign fix).
- Signed overflow (most negative / −1): LO = most negative, HI = 0. This is the natural magnitude result.
- Non-MD instructions never stall, even while md_busy=1.

## Timing
- Reset values: md_busy=0, FSM=IDLE, HI=0, LO=0, iteration counter=0. Reset asserted mid-operation aborts it and leaves HI/LO at 0. issue is ignored during reset.
- Mult/div accepted at edge T:
  - md_busy=1 from after T until after edge T+DATA_W+1.
  - Iterations occur at edges T+1 … T+DATA_W.
  - FIX writes HI/LO at edge T+DATA_W+1.
  - Total latency is DATA_W+1 cycles (33 at DATA_W=32).
- Back-to-back: an MD instruction presented at the cycle after FIX is accepted, since md_busy=0 then.
- mf_data updates in the cycle after any HI/LO write edge. An mfhi following mthi in the next cycle reads the new value.
- Decode outputs, stall and mf_data are purely combinational, with zero latency.

## Test plan
- Decode sweep: ALUop 00/01/11, then ALUop 10 with each listed funct plus funct 111111. Required: ALUControl 0010/0110/0001, the listed codes, and 1111 with illegal=1. jr=1 only for 001000.
- mult a=−3 (0xFFFFFFFD), b=7: md_busy high for exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFEB. A multu with the same operands gives HI=0x00000006, LO=0xFFFFFFEB.
- divu 100/7 → LO=14, HI=2. div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- div 5/0 → LO=0xFFFFFFFF, HI=5 after 33 cycles.
- mfhi issued 2 cycles after a mult:
  - stall=1 until md_busy falls; mf_data then equals the new HI.
  - An add issued during busy never stalls.
  - mthi 0x1234 then mfhi → mf_data=0x00001234.
- Assert reset at cycle 10 of a div: md_busy=0, HI=LO=0 next cycle. A following mult completes normally.
